// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the three-port SRAM arbiter.
package sram_arb_pkg;
  localparam int DEF_ADDR_W = 20;
  localparam int DEF_DATA_W = 16;

  localparam logic [1:0] PORT_DISP = 2'd0;
  localparam logic [1:0] PORT_WR   = 2'd1;
  localparam logic [1:0] PORT_DT   = 2'd2;

  typedef enum logic [1:0] {IDLE, ACC, DATA} state_t;
endpackage

// File: rtl/sram_arb_rr.sv
// Two-requester round-robin picker for the writer (req[0]) and DT engine (req[1]).
module sram_arb_rr (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic [1:0] mask,
  input  logic       advance,
  output logic       pick
);
  logic       ptr;
  logic [1:0] req_m;

  assign req_m = req & ~mask;

  // Preferred side wins unless it is not requesting.
  always_comb begin
    pick = ptr;
    if (!req_m[ptr]) pick = ~ptr;
  end

  always_ff @(posedge clk) begin
    if (!rst)         ptr <= 1'b0;
    else if (advance) ptr <= ~pick;
  end
endmodule

// File: rtl/sram_arbiter.sv
// Single-engine arbiter and pin sequencer for the shared external 16-bit SRAM.
module sram_arbiter
  import sram_arb_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              disp_req,
  input  logic [ADDR_W-1:0] disp_addr,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic              wr_we,
  input  logic [DATA_W-1:0] wr_wdata,
  input  logic [1:0]        wr_be,
  input  logic              dt_req,
  input  logic [ADDR_W-1:0] dt_addr,
  input  logic              dt_we,
  input  logic [DATA_W-1:0] dt_wdata,
  input  logic [1:0]        dt_be,
  output logic              disp_gnt,
  output logic              wr_gnt,
  output logic              dt_gnt,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic [ADDR_W-1:0] SRAM_ADDR,
  inout  wire  [DATA_W-1:0] SRAM_DQ,
  output logic              SRAM_CE_N,
  output logic              SRAM_OE_N,
  output logic              SRAM_WE_N,
  output logic              SRAM_UE_N,
  output logic              SRAM_LE_N
);
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic              we;
    logic [DATA_W-1:0] wdata;
    logic [1:0]        be;
  } acc_t;

  state_t      state, nxt_state;
  acc_t        sel;
  logic [1:0]  sel_port, cur_port;
  logic        cur_we;
  logic [2:0]  gnt_vec, mask, req_m;
  logic        arb_en, sel_valid, rr_pick, rr_adv;
  logic [1:0]  rr_mask;
  logic        dq_oe;
  logic [DATA_W-1:0] dq_out;

  // Arbitration runs in IDLE and DATA; the port finishing (DATA) or just
  // pulsing gnt (IDLE right after DATA) is excluded for that cycle.
  assign arb_en    = (state == IDLE) || (state == DATA);
  assign mask      = (state == DATA) ? (3'b001 << cur_port) : gnt_vec;
  assign req_m     = {dt_req, wr_req, disp_req} & ~mask & {3{arb_en}};
  assign sel_valid = |req_m;
  assign rr_mask   = mask[2:1] | {2{~arb_en}};
  assign rr_adv    = sel_valid & ~req_m[PORT_DISP];

  sram_arb_rr u_rr (
    .clk     (clk),
    .rst     (rst),
    .req     ({dt_req, wr_req}),
    .mask    (rr_mask),
    .advance (rr_adv),
    .pick    (rr_pick)
  );

  always_comb begin
    sel_port = PORT_DISP;
    sel      = '{addr: disp_addr, we: 1'b0, wdata: '0, be: 2'b11};
    if (!req_m[PORT_DISP]) begin
      if (rr_pick) begin
        sel_port = PORT_DT;
        sel      = '{addr: dt_addr, we: dt_we, wdata: dt_wdata, be: dt_be};
      end else begin
        sel_port = PORT_WR;
        sel      = '{addr: wr_addr, we: wr_we, wdata: wr_wdata, be: wr_be};
      end
    end

    nxt_state = state;
    case (state)
      IDLE:    if (sel_valid) nxt_state = ACC;
      ACC:     nxt_state = DATA;
      DATA:    nxt_state = sel_valid ? ACC : IDLE;
      default: nxt_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= nxt_state;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      gnt_vec   <= '0;
      rdata     <= '0;
      cur_port  <= PORT_DISP;
      cur_we    <= 1'b0;
      SRAM_ADDR <= '0;
      SRAM_CE_N <= 1'b1;
      SRAM_OE_N <= 1'b1;
      SRAM_WE_N <= 1'b1;
      SRAM_UE_N <= 1'b1;
      SRAM_LE_N <= 1'b1;
      dq_oe     <= 1'b0;
      dq_out    <= '0;
    end else begin
      gnt_vec <= (state == DATA) ? (3'b001 << cur_port) : 3'b000;
      if (state == DATA && !cur_we) rdata <= SRAM_DQ;

      if (sel_valid) begin
        cur_port  <= sel_port;
        cur_we    <= sel.we;
        SRAM_ADDR <= sel.addr;
        SRAM_CE_N <= 1'b0;
        SRAM_OE_N <= sel.we;
        SRAM_WE_N <= ~sel.we;
        SRAM_UE_N <= ~sel.be[1];
        SRAM_LE_N <= ~sel.be[0];
        dq_oe     <= sel.we;
        dq_out    <= sel.wdata;
      end else if (state == ACC) begin
        // Rising WE_N ends the write; address, data and byte lanes hold.
        SRAM_WE_N <= 1'b1;
      end else begin
        SRAM_CE_N <= 1'b1;
        SRAM_OE_N <= 1'b1;
        SRAM_WE_N <= 1'b1;
        SRAM_UE_N <= 1'b1;
        SRAM_LE_N <= 1'b1;
        dq_oe     <= 1'b0;
      end
    end
  end

  assign SRAM_DQ  = dq_oe ? dq_out : {DATA_W{1'bz}};
  assign busy     = (state != IDLE);
  assign disp_gnt = gnt_vec[PORT_DISP];
  assign wr_gnt   = gnt_vec[PORT_WR];
  assign dt_gnt   = gnt_vec[PORT_DT];
endmodule
